// File: rtl/reg_file_sb_pkg.sv
// Shared types for the reg_file_sb register file.
//   word_t     : one architectural register word (64-bit core)
//   rf_state_t : INIT (clear sweep in progress) / RUN (normal operation)
package reg_file_sb_pkg;

  localparam int unsigned RF_XLEN = 64;

  typedef logic [RF_XLEN-1:0] word_t;

  typedef enum logic {INIT, RUN} rf_state_t;

endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// Busy-bit scoreboard for reg_file_sb: one busy bit per architectural register.
// Priority inside one cycle: writeback clear, then flush clear-all, then issue set.
// The issue set therefore wins over a same-register writeback clear.
// Ports:
//   i_clk, i_reset        : clock, synchronous active-high reset
//   i_run                 : register file is in RUN (wb/flush/issue ignored otherwise)
//   i_iss_valid, i_iss_rd : issue request and its destination
//   i_wb_valid, i_wb_addr : writeback valid/destination per port (err does not matter)
//   i_flush               : clear every busy bit, block issue this cycle
//   o_busy                : busy vector (bit 0 always 0)
//   o_iss_ready           : issue can be accepted this cycle
module reg_file_sb_scoreboard #(
  parameter int unsigned NREG = 32,
  parameter int unsigned NWB  = 2,
  parameter int unsigned AW   = $clog2(NREG)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_run,
  input  logic              i_iss_valid,
  input  logic [AW-1:0]     i_iss_rd,
  input  logic [NWB-1:0]    i_wb_valid,
  input  logic [NWB*AW-1:0] i_wb_addr,
  input  logic              i_flush,
  output logic [NREG-1:0]   o_busy,
  output logic              o_iss_ready
);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_d;
  logic            w_iss_ready;

  // x0 never becomes busy, so an issue to it is always ready.
  assign w_iss_ready = i_run && !i_flush && ((i_iss_rd == '0) || !r_busy[i_iss_rd]);

  always_comb begin
    w_busy_d = r_busy;
    if (i_run) begin
      for (int k = 0; k < NWB; k++) begin
        if (i_wb_valid[k]) w_busy_d[i_wb_addr[k*AW +: AW]] = 1'b0;
      end
      if (i_flush) w_busy_d = '0;
      if (i_iss_valid && w_iss_ready && (i_iss_rd != '0)) w_busy_d[i_iss_rd] = 1'b1;
    end
    w_busy_d[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_busy <= '0;
    else         r_busy <= w_busy_d;
  end

  assign o_busy      = r_busy;
  assign o_iss_ready = w_iss_ready;

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port integer register file with busy scoreboard and retire counter.
// After reset an INIT sweep clears one register per cycle (NREG cycles), then RUN.
// x0 reads as zero and ignores writes.
// Optional macro RF_BYPASS_EN: read ports forward same-cycle writebacks.
// Ports:
//   clk, reset                    : clock, synchronous active-high reset
//   rd_addr/rd_data/rd_busy       : NRD combinational read ports
//   iss_valid/iss_rd/iss_ready    : issue handshake claiming a destination
//   wb_valid/wb_addr/wb_data/wb_err : NWB writeback ports
//   flush                         : clear all busy bits
//   commit/commit_num             : registered retirement report for last cycle
//   retire_cnt                    : total retirements since reset (wraps)
//   init_done                     : high in RUN
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter  int unsigned XLEN = 64,
  parameter  int unsigned NREG = 32,
  parameter  int unsigned NRD  = 2,
  parameter  int unsigned NWB  = 2,
  localparam int unsigned AW   = $clog2(NREG),
  localparam int unsigned CW   = $clog2(NWB + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  output logic                iss_ready,
  input  logic [NWB-1:0]      wb_valid,
  input  logic [NWB*AW-1:0]   wb_addr,
  input  logic [NWB*XLEN-1:0] wb_data,
  input  logic [NWB-1:0]      wb_err,
  input  logic                flush,
  output logic                commit,
  output logic [CW-1:0]       commit_num,
  output logic [63:0]         retire_cnt,
  output logic                init_done
);

  logic [XLEN-1:0] r_rf [NREG];
  rf_state_t       r_state;
  logic [AW-1:0]   r_idx;
  logic            r_commit;
  logic [CW-1:0]   r_commit_num;
  logic [63:0]     r_retire_cnt;

  logic            w_run;
  logic [NREG-1:0] w_busy;
  logic [CW-1:0]   w_n;

  assign w_run = (r_state == RUN);

  reg_file_sb_scoreboard #(
    .NREG (NREG),
    .NWB  (NWB),
    .AW   (AW)
  ) u_scoreboard (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_run       (w_run),
    .i_iss_valid (iss_valid),
    .i_iss_rd    (iss_rd),
    .i_wb_valid  (wb_valid),
    .i_wb_addr   (wb_addr),
    .i_flush     (flush),
    .o_busy      (w_busy),
    .o_iss_ready (iss_ready)
  );

  // INIT sweep FSM; RUN is terminal until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= INIT;
      r_idx   <= '0;
    end else if (r_state == INIT) begin
      r_idx <= r_idx + AW'(1);
      if (r_idx == AW'(NREG - 1)) r_state <= RUN;
    end
  end

  // Register array; later writeback ports overwrite earlier ones on the same address.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == INIT) begin
        r_rf[r_idx] <= '0;
      end else begin
        for (int k = 0; k < NWB; k++) begin
          if (wb_valid[k] && !wb_err[k] && (wb_addr[k*AW +: AW] != '0)) begin
            r_rf[wb_addr[k*AW +: AW]] <= wb_data[k*XLEN +: XLEN];
          end
        end
      end
    end
  end

  // Read ports: zero during INIT and for x0.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int p = 0; p < NRD; p++) begin
      if (w_run && (rd_addr[p*AW +: AW] != '0)) begin
        rd_data[p*XLEN +: XLEN] = r_rf[rd_addr[p*AW +: AW]];
        rd_busy[p]              = w_busy[rd_addr[p*AW +: AW]];
`ifdef RF_BYPASS_EN
        for (int k = 0; k < NWB; k++) begin
          if (wb_valid[k] && (wb_addr[k*AW +: AW] == rd_addr[p*AW +: AW])) begin
            rd_busy[p] = 1'b0;
            if (!wb_err[k]) rd_data[p*XLEN +: XLEN] = wb_data[k*XLEN +: XLEN];
          end
        end
`endif
      end
    end
  end

  // Retirements this cycle; x0 writebacks count, faulting ones do not.
  always_comb begin
    w_n = '0;
    if (w_run) begin
      for (int k = 0; k < NWB; k++) begin
        if (wb_valid[k] && !wb_err[k]) w_n = w_n + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_commit     <= 1'b0;
      r_commit_num <= '0;
      r_retire_cnt <= '0;
    end else begin
      r_commit     <= (w_n != '0);
      r_commit_num <= w_n;
      r_retire_cnt <= r_retire_cnt + 64'(w_n);
    end
  end

  assign commit     = r_commit;
  assign commit_num = r_commit_num;
  assign retire_cnt = r_retire_cnt;
  assign init_done  = w_run;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: expectations are queued when stimulus is driven
// and popped in order when the DUT output is sampled.
module tb_reg_file_sb;

  logic         clk = 1'b0;
  logic         reset;
  logic [9:0]   rd_addr;
  logic [127:0] rd_data;
  logic [1:0]   rd_busy;
  logic         iss_valid;
  logic [4:0]   iss_rd;
  logic         iss_ready;
  logic [1:0]   wb_valid;
  logic [9:0]   wb_addr;
  logic [127:0] wb_data;
  logic [1:0]   wb_err;
  logic         flush;
  logic         commit;
  logic [1:0]   commit_num;
  logic [63:0]  retire_cnt;
  logic         init_done;

  always #5 clk = ~clk;

  reg_file_sb dut (
    .clk        (clk),
    .reset      (reset),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .iss_valid  (iss_valid),
    .iss_rd     (iss_rd),
    .iss_ready  (iss_ready),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .wb_err     (wb_err),
    .flush      (flush),
    .commit     (commit),
    .commit_num (commit_num),
    .retire_cnt (retire_cnt),
    .init_done  (init_done)
  );

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad   = 0;
  logic [63:0] model_cnt = 64'd0;

  task automatic expect_v(input string tag, input logic [63:0] v);
    q.push_back('{tag, v});
  endtask

  task automatic observe(input logic [63:0] o);
    exp_t e;
    total++;
    if (q.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty got=%h want=<queued value>", o);
    end else begin
      e = q.pop_front();
      assert (o === e.val) else begin
        bad++;
        $error("FAIL %s got=%h want=%h", e.tag, o, e.val);
      end
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  initial begin
    int cnt;
    reset     = 1'b1;
    rd_addr   = '0;
    iss_valid = 1'b0;
    iss_rd    = '0;
    wb_valid  = '0;
    wb_addr   = '0;
    wb_data   = '0;
    wb_err    = '0;
    flush     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // INIT: 32 cycles with issue blocked and reads zero; a pending issue must not stick.
    set_rd(5, 0);
    iss_valid = 1'b1;
    iss_rd    = 5'd5;
    wb_valid  = 2'b01;
    wb_addr   = {5'd0, 5'd5};
    wb_data   = {64'd0, 64'h1234};
    for (int i = 0; i < 32; i++) begin
      expect_v("init_iss_ready", 64'd0);
      expect_v("init_done_low", 64'd0);
      expect_v("init_rd5_data", 64'd0);
      expect_v("init_rd5_busy", 64'd0);
      #1;
      observe(iss_ready);
      observe(init_done);
      observe(rd_data[63:0]);
      observe(rd_busy[0]);
      next_cycle();
    end
    iss_valid = 1'b0;
    wb_valid  = '0;
    expect_v("init_done_high", 64'd1);
    expect_v("post_init_r5_busy", 64'd0);
    expect_v("post_init_r5_data", 64'd0);
    expect_v("post_init_retire", 64'd0);
    #1;
    observe(init_done);
    observe(rd_busy[0]);
    observe(rd_data[63:0]);
    observe(retire_cnt);

    // Issue r5, then write it back on port 0.
    set_rd(5, 5);
    iss_valid = 1'b1;
    iss_rd    = 5'd5;
    expect_v("iss_r5_ready", 64'd1);
    #1;
    observe(iss_ready);
    next_cycle();
    iss_valid = 1'b0;
    expect_v("r5_busy_after_issue", 64'd1);
    #1;
    observe(rd_busy[0]);
    wb_valid = 2'b01;
    wb_addr  = {5'd0, 5'd5};
    wb_data  = {64'd0, 64'hDEAD_BEEF};
`ifdef RF_BYPASS_EN
    expect_v("r5_busy_wb_cycle", 64'd0);
    expect_v("r5_data_wb_cycle", 64'hDEAD_BEEF);
`else
    expect_v("r5_busy_wb_cycle", 64'd1);
    expect_v("r5_data_wb_cycle", 64'd0);
`endif
    #1;
    observe(rd_busy[0]);
    observe(rd_data[63:0]);
    next_cycle();
    wb_valid  = '0;
    model_cnt = model_cnt + 64'd1;
    expect_v("r5_commit", 64'd1);
    expect_v("r5_commit_num", 64'd1);
    expect_v("r5_retire_cnt", model_cnt);
    expect_v("r5_busy_after_wb", 64'd0);
    expect_v("r5_data_after_wb", 64'hDEAD_BEEF);
    #1;
    observe(commit);
    observe(commit_num);
    observe(retire_cnt);
    observe(rd_busy[0]);
    observe(rd_data[63:0]);

    // WAW stall on r7, cleared by a faulting writeback that must not write or retire.
    iss_valid = 1'b1;
    iss_rd    = 5'd7;
    next_cycle();
    set_rd(7, 7);
    wb_valid = 2'b01;
    wb_err   = 2'b01;
    wb_addr  = {5'd0, 5'd7};
    wb_data  = {64'd0, 64'h55};
    expect_v("r7_waw_stall", 64'd0);
    #1;
    observe(iss_ready);
    next_cycle();
    wb_valid = '0;
    wb_err   = '0;
    expect_v("r7_ready_after_err_wb", 64'd1);
    expect_v("r7_err_commit", 64'd0);
    expect_v("r7_err_commit_num", 64'd0);
    expect_v("r7_err_retire_cnt", model_cnt);
    expect_v("r7_data_unchanged", 64'd0);
    expect_v("r7_busy_cleared", 64'd0);
    #1;
    observe(iss_ready);
    observe(commit);
    observe(commit_num);
    observe(retire_cnt);
    observe(rd_data[127:64]);
    observe(rd_busy[1]);
    iss_valid = 1'b0;

    // Both writeback ports to r3: port 1 wins the data, two retirements.
    wb_valid = 2'b11;
    wb_addr  = {5'd3, 5'd3};
    wb_data  = {64'h22, 64'h11};
    next_cycle();
    wb_valid  = '0;
    model_cnt = model_cnt + 64'd2;
    set_rd(3, 5);
    expect_v("dual_wb_commit", 64'd1);
    expect_v("dual_wb_commit_num", 64'd2);
    expect_v("dual_wb_retire_cnt", model_cnt);
    expect_v("dual_wb_r3_data", 64'h22);
    expect_v("r5_data_kept", 64'hDEAD_BEEF);
    #1;
    observe(commit);
    observe(commit_num);
    observe(retire_cnt);
    observe(rd_data[63:0]);
    observe(rd_data[127:64]);

    // Busy r1, r2, r4, then flush with a concurrent issue to r9.
    iss_valid = 1'b1;
    iss_rd = 5'd1;
    next_cycle();
    iss_rd = 5'd2;
    next_cycle();
    iss_rd = 5'd4;
    next_cycle();
    iss_valid = 1'b0;
    set_rd(1, 4);
    expect_v("r1_busy_pre_flush", 64'd1);
    expect_v("r4_busy_pre_flush", 64'd1);
    #1;
    observe(rd_busy[0]);
    observe(rd_busy[1]);
    iss_valid = 1'b1;
    iss_rd    = 5'd9;
    flush     = 1'b1;
    expect_v("flush_blocks_issue", 64'd0);
    #1;
    observe(iss_ready);
    next_cycle();
    iss_valid = 1'b0;
    flush     = 1'b0;
    set_rd(1, 9);
    expect_v("r1_busy_post_flush", 64'd0);
    expect_v("r9_not_busy", 64'd0);
    #1;
    observe(rd_busy[0]);
    observe(rd_busy[1]);
    set_rd(2, 4);
    expect_v("r2_busy_post_flush", 64'd0);
    expect_v("r4_busy_post_flush", 64'd0);
    #1;
    observe(rd_busy[0]);
    observe(rd_busy[1]);

    // Writeback to x0: dropped but retired.
    set_rd(0, 0);
    wb_valid = 2'b10;
    wb_addr  = {5'd0, 5'd0};
    wb_data  = {64'hFF, 64'd0};
    expect_v("r0_data_wb_cycle", 64'd0);
    #1;
    observe(rd_data[127:64]);
    next_cycle();
    wb_valid  = '0;
    model_cnt = model_cnt + 64'd1;
    expect_v("r0_data_after_wb", 64'd0);
    expect_v("r0_busy", 64'd0);
    expect_v("r0_commit_num", 64'd1);
    expect_v("r0_retire_cnt", model_cnt);
    #1;
    observe(rd_data[63:0]);
    observe(rd_busy[0]);
    observe(commit_num);
    observe(retire_cnt);

    // Mid-run reset restarts INIT and clears the counters and array.
    reset = 1'b1;
    next_cycle();
    reset     = 1'b0;
    iss_valid = 1'b1;
    iss_rd    = 5'd1;
    set_rd(5, 3);
    expect_v("rst_retire_cnt", 64'd0);
    expect_v("rst_init_done", 64'd0);
    expect_v("rst_commit", 64'd0);
    expect_v("rst_iss_ready", 64'd0);
    expect_v("rst_rd5_data", 64'd0);
    #1;
    observe(retire_cnt);
    observe(init_done);
    observe(commit);
    observe(iss_ready);
    observe(rd_data[63:0]);
    iss_valid = 1'b0;
    cnt = 0;
    while (!init_done && cnt < 40) begin
      next_cycle();
      cnt++;
    end
    expect_v("reinit_cycles", 64'd32);
    expect_v("reinit_r5_cleared", 64'd0);
    expect_v("reinit_r3_cleared", 64'd0);
    #1;
    observe(64'(cnt));
    observe(rd_data[63:0]);
    observe(rd_data[127:64]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
